// File: rtl/field_pkg.sv
// Field constants and FSM state type shared by the multiplier, reducer and
// point-arithmetic stages.
package field_pkg;

  localparam int unsigned FIELD_W = 255;
  localparam int unsigned PROD_W  = 512;
  localparam int unsigned FIELD_C = 19;

  // 2^255 - 19, written as (2^255 - 1) - 18.
  localparam logic [FIELD_W-1:0] P25519 = {FIELD_W{1'b1}} - 255'd18;

  typedef enum logic [1:0] {
    StIdle,
    StFold,
    StSub,
    StDone
  } state_e;

endpackage

// File: rtl/p25519_fold.sv
// Pseudo-Mersenne fold: sum = lo + C*hi, with C*hi built from shifted copies of hi.
module p25519_fold #(
  parameter int unsigned W  = 255,
  parameter int unsigned N  = 257,
  parameter int unsigned C  = 19,
  parameter int unsigned OW = W + 9
) (
  input  logic [W-1:0]  lo,
  input  logic [N-1:0]  hi,
  output logic [OW-1:0] sum
);

  // One shifted copy of hi per set bit of C; C fits in 7 bits.
  always_comb begin
    sum = OW'(lo);
    for (int unsigned i = 0; i < 7; i++) begin
      if (C[i]) begin
        sum = sum + (OW'(hi) << i);
      end
    end
  end

endmodule

// File: rtl/mod_p25519_reduce.sv
// Multi-cycle reducer of a 512-bit product modulo 2^W - C: two folds, one
// conditional subtract, with valid/ready handshakes on both sides.
module mod_p25519_reduce
  import field_pkg::*;
#(
  parameter int unsigned W  = FIELD_W,
  parameter int unsigned PW = PROD_W,
  parameter int unsigned C  = FIELD_C
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] product,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  result
);

  localparam int unsigned AW = W + 9;
  localparam logic [AW-1:0] PMod = (AW'(1) << W) - AW'(C);

  if (C < 1 || C > 127) begin : gen_bad_c
    $error("mod_p25519_reduce: C must be in 1..127");
  end

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [W-1:0]  result_q, result_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] fold_in, fold_acc;

  p25519_fold #(
    .W  (W),
    .N  (PW - W),
    .C  (C),
    .OW (AW)
  ) u_fold_in (
    .lo  (product[W-1:0]),
    .hi  (product[PW-1:W]),
    .sum (fold_in)
  );

  p25519_fold #(
    .W  (W),
    .N  (9),
    .C  (C),
    .OW (AW)
  ) u_fold_acc (
    .lo  (acc_q[W-1:0]),
    .hi  (acc_q[AW-1:W]),
    .sum (fold_acc)
  );

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign out_valid = out_valid_q;
  assign result    = result_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          acc_d   = fold_in;
          state_d = StFold;
        end
      end
      StFold: begin
        acc_d   = fold_acc;
        state_d = StSub;
      end
      StSub: begin
        // acc < 2p, so acc - p fits in W bits and the low-bit difference is exact.
        if (acc_q >= PMod) begin
          result_d = acc_q[W-1:0] - PMod[W-1:0];
        end else begin
          result_d = acc_q[W-1:0];
        end
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            acc_d   = fold_in;
            state_d = StFold;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: doc/mod_p25519_reduce.md
Name: mod_p25519_reduce

Overview:
- Consumes the registered 512-bit product from the 256x256 field-multiplier stage and reduces it modulo p = 2^255 - C, with C = 19 by default (Curve25519 prime).
- Produces a fully reduced 255-bit field element in [0, p-1] for the next point-arithmetic stage.
- Iterative multi-cycle reducer with valid/ready handshakes on both sides: two pseudo-Mersenne folds, one conditional subtract.

Parameters:
- W, 255, field element width; p = 2^W - C.
- PW, 512, input product width.
- C, 19, pseudo-Mersenne constant. Legal range 1..127; out-of-range values fail a static elaboration check.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  product is valid.
- in_ready  out  1  block can accept a product.
- product  in  PW  unsigned product to reduce; any value 0..2^512-1 is legal.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- result  out  W  product mod p, always in [0, p-1].

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, out_valid=0, result=0, internal accumulator=0. in_ready=1 as soon as reset deasserts.
- Accumulator acc is (W+9) bits wide. Intermediate values: L = low W bits, H = upper bits.
- IDLE: in_ready=1. On in_valid&&in_ready, load the fold of product directly: acc <= product[W-1:0] + C*product[PW-1:W]. The bound is < 2^(W+9). Go to FOLD.
- FOLD: acc <= acc[W-1:0] + C*acc[W+8:W]. The bound is < 2^W + 511*C < 2p. Go to SUB.
- SUB: if acc >= p, result <= acc - p; else result <= acc[W-1:0]. Go to DONE, and out_valid goes to 1 on the same edge.
- DONE: out_valid=1. result and out_valid stay stable while out_ready=0.
  - On out_ready=1: out_valid drops next edge; go to IDLE.
  - If in_valid=1 in that same cycle, capture the new product and go straight to FOLD. Drop/accept back-to-back gives one result every 3 cycles.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational from state and out_ready only; no path from in_valid.
- Latency: acceptance edge k -> out_valid=1 after edge k+2.
- Inputs are ignored outside accept cycles; product need not be held after acceptance.
- All arithmetic is unsigned; no intermediate truncation beyond the stated widths. The bounds above guarantee a single subtraction suffices.
- Reset mid-operation: abort immediately. The in-flight product is discarded with no partial output, and the block returns to IDLE.
- No illegal-state lockup: unused state encodings go to IDLE.

Decomposition:
- Shared package (field_pkg), which the multiplier and point-arithmetic stages also use:
  - constants FIELD_W=255, PROD_W=512, FIELD_C=19;
  - P25519 = 2^255-19;
  - state typedef {IDLE, FOLD, SUB, DONE}.
- Sub-module p25519_fold, purely combinational, instantiated twice or shared by mux:
  - inputs: lo[W-1:0], hi[N-1:0];
  - output: lo + C*hi;
  - C*hi is implemented as shift-add ((hi<<4)+(hi<<1)+hi for C=19), with no DSP inference required.

Test Plan:
- Reset, then product=0 -> out_valid after 3 cycles; result=0.
- product=p (2^255-19) -> result=0. product=p-1 -> result=p-1. product=2^255 -> result=19.
- product=2^512-1 -> result=1443. Upstream maximum product (2^256-2)^2 -> result=1296.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Check result stays stable and in_ready=0. Then raise out_ready together with in_valid and a new product=2^256 -> result=38 accepted back-to-back.
- Assert reset low during FOLD -> out_valid=0 and result=0 immediately. After release, no stale output appears, and the next product=5 returns 5.
- Random regression: 10^5 random 512-bit products with random in_valid/out_ready. Compare against a reference model (product % p); check the result ordering and that no result is dropped or duplicated.
